// File: rtl/adc_acq_pkg.sv
// Shared types and constants for the ADC acquisition packer.
// States, header magic and the effective conversion-period helper.
package adc_acq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNV,
        WAIT,
        SHIFT,
        PUSH,
        GAP,
        DONE
    } acq_state_e;

    localparam logic [31:0] HDR_MAGIC = 32'hADC0_0001;

    // A conversion period can never be shorter than CNV + conversion + readout + the PUSH cycle.
    function automatic int eff_period(
        input int sample_period,
        input int t_cnv_hi,
        input int t_conv,
        input int sck_div,
        input int sample_w
    );
        int min_p;
        min_p = t_cnv_hi + t_conv + 2 * sck_div * sample_w + 1;
        return (sample_period > min_p) ? sample_period : min_p;
    endfunction

endpackage

// File: rtl/adc_serial_rx.sv
// Serial readout engine: generates SCK for one conversion and shifts every channel's SDO in, MSB first.
// A start pulse begins a SAMPLE_W-bit readout; done pulses on the last cycle with SCK forced low after it.
module adc_serial_rx #(
    parameter int N_CH     = 8,
    parameter int SAMPLE_W = 16,
    parameter int SCK_DIV  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [N_CH-1:0]          sdo_i,
    output logic                     sck_o,
    output logic                     done_o,
    output logic [N_CH*SAMPLE_W-1:0] data_o
);

    localparam int N_CYC = 2 * SCK_DIV * SAMPLE_W;
    localparam int CNT_W = $clog2(N_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYC - 1);

    logic                          busy_q, busy_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          sck_q, sck_d;
    logic [N_CH-1:0][SAMPLE_W-1:0] shreg_q, shreg_d;

    // Each SCK period is SCK_DIV cycles low followed by SCK_DIV cycles high.
    function automatic logic sck_level(input logic [CNT_W-1:0] cnt);
        return (int'(cnt) % (2 * SCK_DIV)) >= SCK_DIV;
    endfunction

    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        sck_d   = 1'b0;
        shreg_d = shreg_q;
        done_o  = 1'b0;

        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (busy_q) begin
            if (cnt_q == CNT_LAST) begin
                busy_d = 1'b0;
                done_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                sck_d = sck_level(cnt_d);
            end
        end

        // Capture on the same clk edge that raises SCK.
        if (sck_d && !sck_q) begin
            for (int c = 0; c < N_CH; c++) begin
                shreg_d[c] = {shreg_q[c][SAMPLE_W-2:0], sdo_i[c]};
            end
        end
    end

    // NOTE: state updates use <= so all registers see pre-edge values; the shift registers are
    // reset too because they are plain flops, not a RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            sck_q   <= 1'b0;
            shreg_q <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            sck_q   <= sck_d;
            shreg_q <= shreg_d;
        end
    end

    assign sck_o  = sck_q;
    assign data_o = shreg_q;

endmodule

// File: rtl/adc_acq_packer.sv
// Acquisition sequencer: runs CNV/SCK conversions on N_CH serial ADCs and writes one packed word per period.
// Define ADC_ACQ_HEADER_EN to push a header word before the first conversion of every run.
module adc_acq_packer
    import adc_acq_pkg::*;
#(
    parameter int N_CH          = 8,
    parameter int SAMPLE_W      = 16,
    parameter int SCK_DIV       = 2,
    parameter int T_CNV_HI      = 2,
    parameter int T_CONV        = 66,
    parameter int SAMPLE_PERIOD = 200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [31:0]              i_samples_count,
    input  logic                     i_debug_en,
    input  logic                     i_fifo_full,
    input  logic [N_CH-1:0]          i_adc_sdo,
    output logic                     o_adc_cnv,
    output logic                     o_adc_sck,
    output logic [N_CH*SAMPLE_W-1:0] o_data,
    output logic                     o_rdy,
    output logic                     o_finished,
    output logic                     o_start_led,
    output logic                     o_overflow
);

    localparam int W     = N_CH * SAMPLE_W;
    localparam int EFF   = eff_period(SAMPLE_PERIOD, T_CNV_HI, T_CONV, SCK_DIV, SAMPLE_W);
    localparam int PER_W = $clog2(EFF + 1);
    localparam logic [PER_W-1:0] CNV_LAST  = PER_W'(T_CNV_HI - 1);
    localparam logic [PER_W-1:0] WAIT_LAST = PER_W'(T_CNV_HI + T_CONV - 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(EFF - 1);

`ifdef ADC_ACQ_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    acq_state_e       state_q, state_d;
    logic [31:0]      rem_q, rem_d;
    logic             debug_q, debug_d;
    logic             hdr_q, hdr_d;
    logic [12:0]      word_idx_q, word_idx_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [W-1:0]     data_q, data_d;
    logic             overflow_q, overflow_d;
    logic             cnv_q, cnv_d;

    logic             rx_start, rx_done;
    logic [W-1:0]     rx_data;
    logic [W-1:0]     pattern;

    adc_serial_rx #(
        .N_CH     (N_CH),
        .SAMPLE_W (SAMPLE_W),
        .SCK_DIV  (SCK_DIV)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (rx_start),
        .sdo_i   (i_adc_sdo),
        .sck_o   (o_adc_sck),
        .done_o  (rx_done),
        .data_o  (rx_data)
    );

    // Debug word: channel number in the top bits, running word index below.
    always_comb begin
        pattern = '0;
        for (int c = 0; c < N_CH; c++) begin
            pattern[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'({3'(c), word_idx_q});
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        debug_d    = debug_q;
        hdr_d      = hdr_q;
        word_idx_d = word_idx_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        rx_start   = 1'b0;
        period_d   = (state_q == IDLE) ? '0 : period_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    rem_d      = i_samples_count;
                    debug_d    = i_debug_en;
                    word_idx_d = '0;
                    overflow_d = 1'b0;
                    if (HDR_EN) begin
                        hdr_d   = 1'b1;
                        data_d  = W'({HDR_MAGIC, i_samples_count, 31'd0, i_debug_en, 32'd0});
                        state_d = PUSH;
                    end else begin
                        state_d = (i_samples_count == '0) ? DONE : CNV;
                    end
                end
            end
            CNV: begin
                if (period_q == CNV_LAST) state_d = WAIT;
            end
            WAIT: begin
                if (period_q == WAIT_LAST) begin
                    rx_start = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (rx_done) begin
                    data_d  = debug_q ? pattern : rx_data;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (i_fifo_full) overflow_d = 1'b1;
                if (hdr_q) begin
                    hdr_d   = 1'b0;
                    state_d = (rem_q == '0) ? DONE : CNV;
                end else begin
                    // A dropped word still counts, so a run always lasts exactly count periods.
                    rem_d      = rem_q - 32'd1;
                    word_idx_d = word_idx_q + 13'd1;
                    if (period_q >= PER_LAST) state_d = (rem_q == 32'd1) ? DONE : CNV;
                    else                      state_d = GAP;
                end
            end
            GAP: begin
                if (period_q >= PER_LAST) state_d = (rem_q == '0) ? DONE : CNV;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == CNV && state_q != CNV) period_d = '0;
        cnv_d = (state_d == CNV);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            debug_q    <= 1'b0;
            hdr_q      <= 1'b0;
            word_idx_q <= '0;
            period_q   <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            cnv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            debug_q    <= debug_d;
            hdr_q      <= hdr_d;
            word_idx_q <= word_idx_d;
            period_q   <= period_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            cnv_q      <= cnv_d;
        end
    end

    assign o_adc_cnv   = cnv_q;
    assign o_data      = data_q;
    assign o_rdy       = (state_q == PUSH) && !i_fifo_full;
    assign o_finished  = (state_q == DONE);
    assign o_start_led = (state_q != IDLE) && (state_q != DONE);
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_adc_acq_packer.sv
// Self-checking bench for adc_acq_packer: serial ADC model with random samples and a period-level timing model.
// Honours ADC_ACQ_HEADER_EN by expecting the header word ahead of every run.
module tb_adc_acq_packer;

    localparam int N_CH     = 8;
    localparam int PERIOD   = 200;
    localparam int PUSH_OFS = 132;
`ifdef ADC_ACQ_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [31:0]       i_samples_count = '0;
    logic              i_debug_en = 1'b0;
    logic              i_fifo_full = 1'b0;
    logic [N_CH-1:0]   i_adc_sdo;
    logic              o_adc_cnv, o_adc_sck, o_rdy, o_finished, o_start_led, o_overflow;
    logic [N_CH*16-1:0] o_data;

    int   tests = 0;
    int   fails = 0;
    bit   ovf_prev = 1'b0;

    logic [15:0] adc_vals [16][N_CH];
    logic [15:0] adc_sh   [N_CH];
    int          conv_idx = 0;
    logic        run_kick = 1'b0;

    always #5 clk = ~clk;

    adc_acq_packer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .i_samples_count (i_samples_count),
        .i_debug_en      (i_debug_en),
        .i_fifo_full     (i_fifo_full),
        .i_adc_sdo       (i_adc_sdo),
        .o_adc_cnv       (o_adc_cnv),
        .o_adc_sck       (o_adc_sck),
        .o_data          (o_data),
        .o_rdy           (o_rdy),
        .o_finished      (o_finished),
        .o_start_led     (o_start_led),
        .o_overflow      (o_overflow)
    );

    // ADC model: result MSB appears when CNV rises, next bit after every SCK falling edge.
    always @(posedge o_adc_cnv or negedge o_adc_sck or posedge run_kick) begin
        if (run_kick) begin
            conv_idx = 0;
        end else if (o_adc_cnv) begin
            for (int c = 0; c < N_CH; c++) adc_sh[c] = adc_vals[conv_idx % 16][c];
            conv_idx++;
        end else begin
            for (int c = 0; c < N_CH; c++) adc_sh[c] = adc_sh[c] << 1;
        end
        for (int c = 0; c < N_CH; c++) i_adc_sdo[c] = adc_sh[c][15];
    end

    task automatic check(input string tag, input int cyc, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_word(input int k, input bit dbg);
        logic [127:0] w;
        logic [2:0]   ch;
        logic [12:0]  idx;
        w   = '0;
        idx = 13'(k);
        for (int c = 0; c < N_CH; c++) begin
            ch = 3'(c);
            w[c*16 +: 16] = dbg ? {ch, idx} : adc_vals[k % 16][c];
        end
        return w;
    endfunction

    function automatic logic [127:0] hdr_word(input int n, input bit dbg);
        return {32'hADC0_0001, 32'(n), 31'd0, dbg, 32'd0};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_cnv"},  0, o_adc_cnv,   0);
        check({tag, "_sck"},  0, o_adc_sck,   0);
        check({tag, "_data"}, 0, o_data,      0);
        check({tag, "_rdy"},  0, o_rdy,       0);
        check({tag, "_fin"},  0, o_finished,  0);
        check({tag, "_led"},  0, o_start_led, 0);
        check({tag, "_ovf"},  0, o_overflow,  0);
    endtask

    // One run: word k is pushed at cycle HDR+133+200k after the start edge; full_mask bit k blocks
    // word k, bit 15 blocks the header. abort_at>0 pulses reset in that cycle and ends the run there.
    task automatic run_acq(input int n, input bit dbg, input logic [15:0] full_mask,
                           input int extra_start_at, input int abort_at, input bit directed);
        int fin_t, cnv_rises, sck_rises, noise;
        bit prev_sck, prev_cnv, dropped;
        for (int k = 0; k < 16; k++)
            for (int c = 0; c < N_CH; c++) adc_vals[k][c] = 16'($urandom);
        if (directed) begin
            adc_vals[0][0]      = 16'hA5C3;
            adc_vals[0][N_CH-1] = 16'h8001;
        end
        fin_t = (n == 0) ? 1 + HDR : HDR + PERIOD * n + 1;
        check("ovf_sticky", 0, o_overflow, ovf_prev);
        run_kick = 1'b1;
        #1 run_kick = 1'b0;

        @(posedge clk); #1;
        i_start = 1'b1; i_samples_count = 32'(n); i_debug_en = dbg;
        @(posedge clk); #1;
        i_start = 1'b0; i_samples_count = $urandom; i_debug_en = 1'($urandom);
        cnv_rises = 0; sck_rises = 0; prev_sck = 1'b0; prev_cnv = 1'b0; dropped = 1'b0;

        for (int cyc = 1; cyc <= fin_t + 3; cyc++) begin
            int k, ofs;
            bit active, is_push, is_hdr, full, cnv_exp;
            is_hdr  = (HDR == 1) && (cyc == 1);
            k       = (cyc - HDR - 1) / PERIOD;
            ofs     = (cyc - HDR - 1) % PERIOD;
            active  = (cyc > HDR) && (k < n);
            is_push = active && (ofs == PUSH_OFS);
            cnv_exp = active && (ofs < 2);
            full    = is_hdr ? full_mask[15] : (active && full_mask[k[3:0]]);
            i_fifo_full = full;
            i_start     = (cyc == extra_start_at);
            if (i_start) i_samples_count = 32'd7;
            if (cyc == abort_at) rst_n = 1'b0;

            @(negedge clk);
            check("rdy",      cyc, o_rdy,      (is_push || is_hdr) && !full);
            check("finished", cyc, o_finished, cyc == fin_t);
            check("cnv",      cyc, o_adc_cnv,  cnv_exp);
            check("overflow", cyc, o_overflow, dropped);
            if (cyc < fin_t)      check("led_run",  cyc, o_start_led, 1);
            else if (cyc > fin_t) check("led_idle", cyc, o_start_led, 0);
            if (is_hdr)  check("hdr_data", cyc, o_data, hdr_word(n, dbg));
            if (is_push) check("data",     cyc, o_data, exp_word(k, dbg));
            if ((is_push || is_hdr) && full) dropped = 1'b1;
            if (o_adc_sck && !prev_sck) sck_rises++;
            if (o_adc_cnv && !prev_cnv) cnv_rises++;
            prev_sck = o_adc_sck;
            prev_cnv = o_adc_cnv;

            @(posedge clk); #1;
            i_start = 1'b0;
            if (cyc == abort_at) begin
                rst_n       = 1'b1;
                i_fifo_full = 1'b0;
                @(negedge clk);
                check_all_zero("abort");
                noise = 0;
                repeat (PERIOD * 4) begin
                    @(negedge clk);
                    if (o_finished || o_rdy || o_adc_cnv || o_adc_sck) noise++;
                end
                check("quiet_after_reset", 0, noise, 0);
                ovf_prev = 1'b0;
                return;
            end
        end
        check("cnv_rises", 0, cnv_rises, n);
        check("sck_rises", 0, sck_rises, 16 * n);
        ovf_prev = dropped;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        // debug pattern, three words, stray start while busy
        run_acq(3, 1'b1, 16'h0000, 250, 0, 1'b0);
        // directed ADC values on ch0 / ch7
        run_acq(1, 1'b0, 16'h0000, 0, 0, 1'b1);
        // empty run
        run_acq(0, 1'b0, 16'h0000, 0, 0, 1'b0);
        // FIFO full on the second of four words
        run_acq(4, 1'b0, 16'h0002, 0, 0, 1'b0);
        // reset during readout of the second word, then a clean restart
        run_acq(3, 1'b0, 16'h0000, 0, HDR + PERIOD + 80, 1'b0);
        run_acq(3, 1'b0, 16'h0000, 0, 0, 1'b0);
        // five-word run (header first when enabled)
        run_acq(5, 1'b0, 16'h0000, 0, 0, 1'b0);
        // randomized runs
        repeat (2) run_acq(int'($urandom_range(1, 3)), 1'($urandom), 16'($urandom) & 16'h8007, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
